// File: rtl/move_scheduler_if.sv
// move_scheduler_if: child-position stream from move_scheduler to its consumer
// (evaluator, display, search stack).
//
// Handshake: out_valid/out_ready. A transfer happens on a rising clock edge
// where both are high. Once out_valid rises, the producer holds out_valid and
// every payload field (out_board, out_white_to_move, out_castle_mask,
// out_en_passant_col, out_index) stable until that transfer. out_valid never
// depends combinationally on out_ready.
//
// Parameters:
//   BOARD_WIDTH  bits per board
//   IDX_WIDTH    move index width
// Modports:
//   master  producer side (drives out_valid and payload, samples out_ready)
//   slave   consumer side

`ifndef PIECE_BITS
`define PIECE_BITS 4
`endif
`ifndef MAX_POSITIONS
`define MAX_POSITIONS 256
`endif

interface move_scheduler_if #(
    parameter int BOARD_WIDTH = `PIECE_BITS * 64,
    parameter int IDX_WIDTH   = $clog2(`MAX_POSITIONS)
);
    logic                   out_valid;
    logic                   out_ready;
    logic [BOARD_WIDTH-1:0] out_board;
    logic                   out_white_to_move;
    logic [3:0]             out_castle_mask;
    logic [3:0]             out_en_passant_col;
    logic [IDX_WIDTH-1:0]   out_index;

    modport master (
        output out_valid, out_board, out_white_to_move, out_castle_mask,
               out_en_passant_col, out_index,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_board, out_white_to_move, out_castle_mask,
               out_en_passant_col, out_index,
        output out_ready
    );
endinterface

// File: rtl/move_scheduler.sv
// move_scheduler: sequences one expansion of an all_moves generator.
// It loads a root position, waits for move generation, then reads every
// generated child through the move RAM and hands each child to a consumer
// over out_if. When all children are delivered, it pulses clear_moves so
// the generator is ready for the next position.
//
// Optional feature macro: MOVE_SCHED_ABORT_EN adds an 'abort' input. When
// abort is high in WAIT_GEN, FETCH_0, FETCH_1 or PRESENT, the scheduler drops
// out_valid and jumps to CLEAR.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, *_in           expansion request and root position (used in IDLE)
//   busy                  high in every state except IDLE
//   gen_board_valid       one-cycle load pulse to the generator
//   gen_board, gen_*      registered root, held while busy
//   gen_moves_ready       generation finished (honoured in WAIT_GEN only)
//   gen_move_count        number of generated moves
//   gen_move_index        move RAM read address
//   gen_clear_moves       one-cycle generator clear pulse
//   gen_*_out             move RAM read data
//   out_if                child-position stream (master side)
//   done, done_count      end-of-expansion pulse and number of moves delivered
//   dbg_state             current FSM state encoding
//   abort                 (MOVE_SCHED_ABORT_EN only) cut the expansion short

`ifndef PIECE_BITS
`define PIECE_BITS 4
`endif
`ifndef MAX_POSITIONS
`define MAX_POSITIONS 256
`endif

module move_scheduler #(
    parameter int PIECE_WIDTH        = `PIECE_BITS,
    parameter int SIDE_WIDTH         = PIECE_WIDTH * 8,
    parameter int BOARD_WIDTH        = PIECE_WIDTH * 64,
    parameter int MAX_POSITIONS      = `MAX_POSITIONS,
    parameter int MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [BOARD_WIDTH-1:0]        board_in,
    input  logic                          white_to_move_in,
    input  logic [3:0]                    castle_mask_in,
    input  logic [3:0]                    en_passant_col_in,
    output logic                          busy,
    output logic                          gen_board_valid,
    output logic [BOARD_WIDTH-1:0]        gen_board,
    output logic                          gen_white_to_move,
    output logic [3:0]                    gen_castle_mask,
    output logic [3:0]                    gen_en_passant_col,
    input  logic                          gen_moves_ready,
    input  logic [MAX_POSITIONS_LOG2-1:0] gen_move_count,
    output logic [MAX_POSITIONS_LOG2-1:0] gen_move_index,
    output logic                          gen_clear_moves,
    input  logic [BOARD_WIDTH-1:0]        gen_board_out,
    input  logic                          gen_white_to_move_out,
    input  logic [3:0]                    gen_castle_mask_out,
    input  logic [3:0]                    gen_en_passant_col_out,
    move_scheduler_if.master              out_if,
    output logic                          done,
    output logic [MAX_POSITIONS_LOG2-1:0] done_count,
`ifdef MOVE_SCHED_ABORT_EN
    input  logic                          abort,
`endif
    output logic [3:0]                    dbg_state
);

    localparam int L = MAX_POSITIONS_LOG2;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        LOAD       = 4'd1,
        WAIT_GEN   = 4'd2,
        FETCH_0    = 4'd3,
        FETCH_1    = 4'd4,
        PRESENT    = 4'd5,
        CLEAR      = 4'd6,
        CLEAR_WAIT = 4'd7,
        DONE       = 4'd8
    } state_t;

    state_t                 state_q, state_d;
    logic                   busy_q, busy_d;
    logic                   board_valid_q, board_valid_d;
    logic                   clear_q, clear_d;
    logic                   done_q, done_d;
    logic [BOARD_WIDTH-1:0] root_board_q, root_board_d;
    logic                   root_wtm_q, root_wtm_d;
    logic [3:0]             root_castle_q, root_castle_d;
    logic [3:0]             root_ep_q, root_ep_d;
    logic [L-1:0]           index_q, index_d;
    logic [L-1:0]           count_q, count_d;
    logic [L-1:0]           xfer_q, xfer_d;
    logic [L-1:0]           done_count_q, done_count_d;
    logic                   out_valid_q, out_valid_d;
    logic [BOARD_WIDTH-1:0] out_board_q, out_board_d;
    logic                   out_wtm_q, out_wtm_d;
    logic [3:0]             out_castle_q, out_castle_d;
    logic [3:0]             out_ep_q, out_ep_d;
    logic [L-1:0]           out_index_q, out_index_d;

    // One extra bit so a count of MAX_POSITIONS-1 ends cleanly instead of
    // wrapping the index back to 0.
    logic [L:0] index_next_w;
    logic       handshake;
    logic       abort_hit;

    assign index_next_w = {1'b0, index_q} + {{L{1'b0}}, 1'b1};
    assign handshake    = out_valid_q && out_if.out_ready;

`ifdef MOVE_SCHED_ABORT_EN
    assign abort_hit = abort && ((state_q == WAIT_GEN) || (state_q == FETCH_0) ||
                                 (state_q == FETCH_1)  || (state_q == PRESENT));
`else
    assign abort_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        board_valid_d = 1'b0;
        clear_d       = 1'b0;
        done_d        = 1'b0;
        root_board_d  = root_board_q;
        root_wtm_d    = root_wtm_q;
        root_castle_d = root_castle_q;
        root_ep_d     = root_ep_q;
        index_d       = index_q;
        count_d       = count_q;
        xfer_d        = xfer_q;
        done_count_d  = done_count_q;
        out_valid_d   = out_valid_q;
        out_board_d   = out_board_q;
        out_wtm_d     = out_wtm_q;
        out_castle_d  = out_castle_q;
        out_ep_d      = out_ep_q;
        out_index_d   = out_index_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    root_board_d  = board_in;
                    root_wtm_d    = white_to_move_in;
                    root_castle_d = castle_mask_in;
                    root_ep_d     = en_passant_col_in;
                    index_d       = '0;
                    xfer_d        = '0;
                    board_valid_d = 1'b1;
                    state_d       = LOAD;
                end
            end
            LOAD: state_d = WAIT_GEN;
            WAIT_GEN: begin
                if (gen_moves_ready) begin
                    count_d = gen_move_count;
                    index_d = '0;
                    if (gen_move_count == '0) begin
                        clear_d = 1'b1;
                        state_d = CLEAR;
                    end else begin
                        state_d = FETCH_0;
                    end
                end
            end
            FETCH_0: state_d = FETCH_1;
            FETCH_1: begin
                out_board_d  = gen_board_out;
                out_wtm_d    = gen_white_to_move_out;
                out_castle_d = gen_castle_mask_out;
                out_ep_d     = gen_en_passant_col_out;
                out_index_d  = index_q;
                out_valid_d  = 1'b1;
                state_d      = PRESENT;
            end
            PRESENT: begin
                if (handshake) begin
                    out_valid_d = 1'b0;
                    xfer_d      = xfer_q + {{(L-1){1'b0}}, 1'b1};
                    if (index_next_w < {1'b0, count_q}) begin
                        index_d = index_next_w[L-1:0];
                        state_d = FETCH_0;
                    end else begin
                        clear_d = 1'b1;
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: state_d = CLEAR_WAIT;
            CLEAR_WAIT: begin
                done_d       = 1'b1;
                done_count_d = xfer_q;
                state_d      = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A transfer completing in the same cycle as abort still counts.
        if (abort_hit) begin
            out_valid_d = 1'b0;
            clear_d     = 1'b1;
            state_d     = CLEAR;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            board_valid_q <= 1'b0;
            clear_q       <= 1'b0;
            done_q        <= 1'b0;
            root_board_q  <= '0;
            root_wtm_q    <= 1'b0;
            root_castle_q <= '0;
            root_ep_q     <= '0;
            index_q       <= '0;
            count_q       <= '0;
            xfer_q        <= '0;
            done_count_q  <= '0;
            out_valid_q   <= 1'b0;
            out_board_q   <= '0;
            out_wtm_q     <= 1'b0;
            out_castle_q  <= '0;
            out_ep_q      <= '0;
            out_index_q   <= '0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            board_valid_q <= board_valid_d;
            clear_q       <= clear_d;
            done_q        <= done_d;
            root_board_q  <= root_board_d;
            root_wtm_q    <= root_wtm_d;
            root_castle_q <= root_castle_d;
            root_ep_q     <= root_ep_d;
            index_q       <= index_d;
            count_q       <= count_d;
            xfer_q        <= xfer_d;
            done_count_q  <= done_count_d;
            out_valid_q   <= out_valid_d;
            out_board_q   <= out_board_d;
            out_wtm_q     <= out_wtm_d;
            out_castle_q  <= out_castle_d;
            out_ep_q      <= out_ep_d;
            out_index_q   <= out_index_d;
        end
    end

    assign busy                      = busy_q;
    assign gen_board_valid           = board_valid_q;
    assign gen_board                 = root_board_q;
    assign gen_white_to_move         = root_wtm_q;
    assign gen_castle_mask           = root_castle_q;
    assign gen_en_passant_col        = root_ep_q;
    assign gen_move_index            = index_q;
    assign gen_clear_moves           = clear_q;
    assign done                      = done_q;
    assign done_count                = done_count_q;
    assign dbg_state                 = state_q;
    assign out_if.out_valid          = out_valid_q;
    assign out_if.out_board          = out_board_q;
    assign out_if.out_white_to_move  = out_wtm_q;
    assign out_if.out_castle_mask    = out_castle_q;
    assign out_if.out_en_passant_col = out_ep_q;
    assign out_if.out_index          = out_index_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with a combinational mock move RAM.
// Runs with MAX_POSITIONS = 8 so the count = MAX_POSITIONS-1 case is short.

module tb_move_scheduler;

    localparam int BW = 256;
    localparam int L  = 3;

    logic          clk;
    logic          reset;
    logic          start;
    logic [BW-1:0] board_in;
    logic          white_to_move_in;
    logic [3:0]    castle_mask_in;
    logic [3:0]    en_passant_col_in;
    logic          busy;
    logic          gen_board_valid;
    logic [BW-1:0] gen_board;
    logic          gen_white_to_move;
    logic [3:0]    gen_castle_mask;
    logic [3:0]    gen_en_passant_col;
    logic          gen_moves_ready;
    logic [L-1:0]  gen_move_count;
    logic [L-1:0]  gen_move_index;
    logic          gen_clear_moves;
    logic [BW-1:0] gen_board_out;
    logic          gen_white_to_move_out;
    logic [3:0]    gen_castle_mask_out;
    logic [3:0]    gen_en_passant_col_out;
    logic          done;
    logic [L-1:0]  done_count;
    logic [3:0]    dbg_state;
`ifdef MOVE_SCHED_ABORT_EN
    logic          abort;
`endif

    logic [31:0]   ram_seed;
    int            tests;
    int            fails;
    int            clr_cnt;
    logic [BW-1:0] exp_q[$];

    move_scheduler_if #(.BOARD_WIDTH(BW), .IDX_WIDTH(L)) out_if ();

    move_scheduler #(
        .PIECE_WIDTH(4), .MAX_POSITIONS(8), .MAX_POSITIONS_LOG2(L)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .board_in(board_in), .white_to_move_in(white_to_move_in),
        .castle_mask_in(castle_mask_in), .en_passant_col_in(en_passant_col_in),
        .busy(busy), .gen_board_valid(gen_board_valid),
        .gen_board(gen_board), .gen_white_to_move(gen_white_to_move),
        .gen_castle_mask(gen_castle_mask), .gen_en_passant_col(gen_en_passant_col),
        .gen_moves_ready(gen_moves_ready), .gen_move_count(gen_move_count),
        .gen_move_index(gen_move_index), .gen_clear_moves(gen_clear_moves),
        .gen_board_out(gen_board_out), .gen_white_to_move_out(gen_white_to_move_out),
        .gen_castle_mask_out(gen_castle_mask_out),
        .gen_en_passant_col_out(gen_en_passant_col_out),
        .out_if(out_if), .done(done), .done_count(done_count),
`ifdef MOVE_SCHED_ABORT_EN
        .abort(abort),
`endif
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- mock move RAM ----------------
    function automatic logic [BW-1:0] mk_board(input logic [L-1:0] idx, input logic [31:0] sd);
        logic [31:0] w;
        w = (sd ^ ({29'd0, idx} * 32'h0101_0101)) + {29'd0, idx};
        return {8{w}};
    endfunction

    assign gen_board_out          = mk_board(gen_move_index, ram_seed);
    assign gen_white_to_move_out  = gen_move_index[0];
    assign gen_castle_mask_out    = {1'b0, gen_move_index} ^ 4'hA;
    assign gen_en_passant_col_out = {1'b1, gen_move_index};

    always @(negedge clk) if (gen_clear_moves === 1'b1) clr_cnt++;

    // ---------------- driver / check tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [31:0] root);
        board_in          = {8{root}};
        white_to_move_in  = root[0];
        castle_mask_in    = root[7:4];
        en_passant_col_in = root[11:8];
        start = 1'b1;
        tick();                               // T+1: LOAD
        start = 1'b0;
        chk("load_pulse", gen_board_valid, 1'b1);
        chk("load_busy", busy, 1'b1);
        chk("root_board", gen_board, {8{root}});
        chk("root_castle", gen_castle_mask, root[7:4]);
        board_in = '1;                        // root must stay latched
        tick();                               // WAIT_GEN
        chk("load_one_cycle", gen_board_valid, 1'b0);
        chk("root_held", gen_board, {8{root}});
    endtask

    // Call in WAIT_GEN. stall = cycles with out_ready low per move.
    task automatic run_moves(input int n, input int stall, input logic [31:0] sd, input bit poke_start);
        int clr0;
        logic [L-1:0] iv;
        logic [BW-1:0] eb;
        clr0 = clr_cnt;
        ram_seed = sd;
        for (int i = 0; i < n; i++) exp_q.push_back(mk_board(i[L-1:0], sd));
        gen_move_count  = n[L-1:0];
        gen_moves_ready = 1'b1;
        out_ready_drv(stall == 0);
        tick();                               // M+1
        chk("m1_valid_low", out_if.out_valid, 1'b0);
        chk("m1_index_zero", gen_move_index, '0);
        if (n == 0) begin
            chk("zero_clear_m1", gen_clear_moves, 1'b1);
        end else begin
            tick();                           // M+2
            chk("m2_valid_low", out_if.out_valid, 1'b0);
            tick();                           // M+3
            for (int i = 0; i < n; i++) begin
                iv = i[L-1:0];
                eb = exp_q.pop_front();
                chk("present_valid", out_if.out_valid, 1'b1);
                chk("present_index", out_if.out_index, iv);
                chk("present_board", out_if.out_board, eb);
                chk("present_wtm", out_if.out_white_to_move, iv[0]);
                chk("present_castle", out_if.out_castle_mask, {1'b0, iv} ^ 4'hA);
                chk("present_ep", out_if.out_en_passant_col, {1'b1, iv});
                for (int s = 0; s < stall; s++) begin
                    out_ready_drv(1'b0);
                    if (poke_start && s == 1) start = 1'b1;
                    tick();
                    if (poke_start && s == 1) begin
                        start = 1'b0;
                        chk("start_ignored", gen_board_valid, 1'b0);
                    end
                    chk("stall_valid", out_if.out_valid, 1'b1);
                    chk("stall_board", out_if.out_board, eb);
                    chk("stall_index", out_if.out_index, iv);
                    chk("stall_gen_index", gen_move_index, iv);
                end
                out_ready_drv(1'b1);
                tick();                       // H+1
                chk("h1_valid_low", out_if.out_valid, 1'b0);
                if (i < n - 1) begin
                    chk("h1_index_inc", gen_move_index, iv + 1'b1);
                    chk("h1_no_clear", gen_clear_moves, 1'b0);
                    tick();
                    chk("h2_valid_low", out_if.out_valid, 1'b0);
                    tick();                   // H+3
                end else begin
                    chk("last_clear", gen_clear_moves, 1'b1);
                end
            end
        end
        gen_moves_ready = 1'b0;
        out_ready_drv(1'b0);
        tick();                               // +2
        chk("clear_one_cycle", gen_clear_moves, 1'b0);
        chk("done_not_yet", done, 1'b0);
        tick();                               // +3
        chk("done_pulse", done, 1'b1);
        chk("done_count", done_count, n[L-1:0]);
        chk("done_busy", busy, 1'b1);
        tick();                               // +4
        chk("idle_busy", busy, 1'b0);
        chk("done_low", done, 1'b0);
        chk("done_count_held", done_count, n[L-1:0]);
        chk("single_clear", clr_cnt - clr0, 1);
    endtask

    task automatic out_ready_drv(input logic v);
        out_if.out_ready = v;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        tests = 0; fails = 0; clr_cnt = 0;
        reset = 1'b1; start = 1'b0; board_in = '0; white_to_move_in = 1'b0;
        castle_mask_in = '0; en_passant_col_in = '0;
        gen_moves_ready = 1'b0; gen_move_count = '0; ram_seed = 32'h0;
        out_if.out_ready = 1'b0;
`ifdef MOVE_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_state", dbg_state, 4'd0);
        chk("rst_valid", out_if.out_valid, 1'b0);
        chk("rst_gen_board", gen_board, '0);
        chk("rst_done_count", done_count, '0);
        chk("rst_clear", gen_clear_moves, 1'b0);

        // count 3, ready tied high
        do_start(32'h1357_9BDF);
        run_moves(3, 0, 32'hA5A5_0F0F, 1'b0);

        // count 3, 5-cycle stall per move, start poked during PRESENT
        do_start(32'h2468_ACE0);
        run_moves(3, 5, 32'h5A5A_F0F0, 1'b1);

        // zero moves
        do_start(32'h0F1E_2D3C);
        run_moves(0, 0, 32'h0, 1'b0);

        // count = MAX_POSITIONS-1, must not wrap
        do_start(32'h7777_1111);
        run_moves(7, 0, 32'h3C3C_C3C3, 1'b0);

        // reset during FETCH_1 of move 2
        begin
            int clr0;
            clr0 = clr_cnt;
            do_start(32'h9999_0000);
            ram_seed = 32'h1111_2222;
            gen_move_count = 3'd3; gen_moves_ready = 1'b1; out_if.out_ready = 1'b1;
            tick(); tick(); tick();          // PRESENT move 0
            tick();                          // FETCH_0 move 1
            tick();                          // FETCH_1 move 1
            chk("pre_rst_state", dbg_state, 4'd4);
            reset = 1'b1;
            tick();
            reset = 1'b0; gen_moves_ready = 1'b0; out_if.out_ready = 1'b0;
            chk("mid_rst_busy", busy, 1'b0);
            chk("mid_rst_state", dbg_state, 4'd0);
            chk("mid_rst_index", gen_move_index, '0);
            chk("mid_rst_gen_board", gen_board, '0);
            chk("mid_rst_out_board", out_if.out_board, '0);
            chk("mid_rst_valid", out_if.out_valid, 1'b0);
            tick();
            chk("mid_rst_no_clear", clr_cnt - clr0, 0);
            chk("mid_rst_idle", busy, 1'b0);
        end

`ifdef MOVE_SCHED_ABORT_EN
        // count 5, abort after second transfer
        do_start(32'hABCD_1234);
        ram_seed = 32'h0BAD_F00D;
        gen_move_count = 3'd5; gen_moves_ready = 1'b1; out_if.out_ready = 1'b1;
        tick(); tick(); tick();              // PRESENT move 0
        tick(); tick(); tick();              // PRESENT move 1
        chk("ab_index1", out_if.out_index, 3'd1);
        tick();                              // FETCH_0 of move 2
        abort = 1'b1;
        tick();
        abort = 1'b0; gen_moves_ready = 1'b0; out_if.out_ready = 1'b0;
        chk("ab_clear", gen_clear_moves, 1'b1);
        chk("ab_state", dbg_state, 4'd6);
        chk("ab_valid", out_if.out_valid, 1'b0);
        tick(); tick();
        chk("ab_done", done, 1'b1);
        chk("ab_done_count", done_count, 3'd2);
        tick();
        chk("ab_idle", busy, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/move_scheduler.md
# move_scheduler

Sequencer that drives `all_moves` for one position. It loads a board, waits for generation to finish, and walks `move_index` through every generated move. Each resulting position goes to a downstream consumer (evaluator, display, search stack) over a valid/ready handshake, and the scheduler then issues `clear_moves` so the generator is ready for the next position. It sits between the search controller and the `all_moves` instance, replacing hand-written sequencing loops.

## Interface
- `PIECE_WIDTH`, default `` `PIECE_BITS``: bits per square.
- `SIDE_WIDTH`, default `PIECE_WIDTH*8`: bits per rank.
- `BOARD_WIDTH`, default `PIECE_WIDTH*64`: bits per board.
- `MAX_POSITIONS`, default `` `MAX_POSITIONS``: generator move RAM depth.
- `MAX_POSITIONS_LOG2`, default `$clog2(MAX_POSITIONS)`: index/count width.

Ports:
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  request to expand the position on `*_in`; sampled only in IDLE.
- `board_in`, `white_to_move_in`, `castle_mask_in`, `en_passant_col_in`  in  BOARD_WIDTH/1/4/4  root position.
- `busy`  out  1  high in every state except IDLE.
- `gen_board_valid`  out  1  one-cycle load pulse to `all_moves.board_valid`.
- `gen_board`, `gen_white_to_move`, `gen_castle_mask`, `gen_en_passant_col`  out  BOARD_WIDTH/1/4/4  registered copy of root, held stable while busy.
- `gen_moves_ready`  in  1  from `all_moves.moves_ready`.
- `gen_move_count`  in  MAX_POSITIONS_LOG2  from `all_moves.move_count`.
- `gen_move_index`  out  MAX_POSITIONS_LOG2  to `all_moves.move_index`.
- `gen_clear_moves`  out  1  one-cycle pulse to `all_moves.clear_moves`.
- `gen_board_out`, `gen_white_to_move_out`, `gen_castle_mask_out`, `gen_en_passant_col_out`  in  BOARD_WIDTH/1/4/4  move RAM read data.
- `out_valid`  out  1  child position available.
- `out_ready`  in  1  consumer accepts.
- `out_board`, `out_white_to_move`, `out_castle_mask`, `out_en_passant_col`  out  BOARD_WIDTH/1/4/4  registered child position.
- `out_index`  out  MAX_POSITIONS_LOG2  index of the child being presented.
- `done`  out  1  one-cycle pulse at end of expansion.
- `done_count`  out  MAX_POSITIONS_LOG2  moves delivered; valid with `done`, held until next `done`.

## Operation
- **States:** IDLE, LOAD, WAIT_GEN, FETCH_0, FETCH_1, PRESENT, CLEAR, CLEAR_WAIT, DONE.
- **IDLE:** on `start`, latch the root into `gen_*` and go to LOAD.
- **LOAD:** `gen_board_valid`=1, then WAIT_GEN.
- **WAIT_GEN:** when `gen_moves_ready`, latch the count and set `gen_move_index`=0. A count of 0 (mate or stalemate) goes to CLEAR; otherwise FETCH_0.
- **FETCH_0, FETCH_1:** RAM latency wait states. At the end of FETCH_1, capture the RAM outputs and the index into the `out_*` registers, then go to PRESENT.
- **PRESENT:** `out_valid`=1, with `out_*` stable until `out_ready`.
  - On transfer, if index+1 < count: increment `gen_move_index` and go to FETCH_0.
  - Otherwise go to CLEAR.
- **CLEAR:** `gen_clear_moves`=1, then CLEAR_WAIT. CLEAR_WAIT is one idle cycle for the generator reset.
- **DONE:** `done`=1, `done_count` = moves transferred, then IDLE.
- `start` while busy is ignored and not queued.
- `gen_moves_ready` is ignored outside WAIT_GEN.
- Index arithmetic is unsigned. Count equal to MAX_POSITIONS-1 must finish without index wrap (compare uses one extra bit).

## Timing
- **Reset values:** all outputs 0 (`busy`, `gen_board_valid`, `gen_clear_moves`, `out_valid`, `done`, indices, counts, data registers). State is IDLE.
- **Start:** `start` at cycle T puts `gen_board_valid` high at T+1 only; `busy` is high from T+1.
- **First move:** `gen_moves_ready` sampled at M puts `out_valid` high at M+3.
- **Subsequent moves:** handshake at H puts `out_valid` low at H+1..H+2 and high again at H+3. Throughput is at most one move per 3 cycles.
- **Finish:** last handshake at H gives `gen_clear_moves` at H+1, `done` at H+3, and IDLE (busy=0) at H+4.
- **Zero moves:** `gen_moves_ready` at M gives `gen_clear_moves` at M+1 and `done` at M+3 with `done_count`=0.
- **Reset mid-operation:** immediate return to IDLE with outputs cleared, no `gen_clear_moves` issued. `all_moves` shares `reset`.

## Configuration
- `MOVE_SCHED_ABORT_EN` defined: adds input `abort` (1 bit).
  - `abort` high in any state from WAIT_GEN through PRESENT drops `out_valid` next cycle and jumps to CLEAR.
  - `done_count` = transfers completed before abort.
  - `abort` in IDLE, LOAD, CLEAR, CLEAR_WAIT or DONE is ignored.
- Undefined: no `abort` port. Every expansion runs to completion.

## Test plan
- Mock generator with count 3, `out_ready` tied 1 → three transfers, indices 0,1,2, boards matching RAM entries. One `gen_clear_moves`, then `done` with `done_count`=3 at last handshake+3.
- Same with `out_ready` low for 5 cycles per move → `out_*` stable while stalled, no extra index increments, `done_count`=3.
- Count 0 → no `out_valid`, `gen_clear_moves` at M+1, `done` at M+3 with `done_count`=0.
- `start` pulsed during PRESENT → ignored. Second `start` after `done` → fresh `gen_board_valid`, index restarts at 0.
- `reset` asserted during FETCH_1 of move 2 → next cycle all outputs 0, IDLE, no clear pulse.
- With `MOVE_SCHED_ABORT_EN`, count 5, `abort` after second transfer → CLEAR next cycle, `done_count`=2.
